mem_stage: RTL

- Memory stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM latch outputs and drives the data-cache request/hit handshake.
- Resolves branches and jumps (redirect plus flush of the upstream latches).
- Holds the MEM/WB latch that feeds register-file writeback; also keeps the sticky halt and a memory-stall performance counter.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_if.sv | 64 ++++++
 rtl/mem_stage_branch_resolve.sv | 37 +++
 rtl/mem_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS memory stage.
package mem_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam logic [REG_W-1:0] RA_REG = 5'd31;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } mem_state_t;

    // j/jal target: upper PC nibble, 26-bit index, word aligned
    function automatic logic [WORD_W-1:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM latch fields, data-cache handshake and MEM-stage results.
interface mem_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
);
    logic [DATA_W-1:0] pcMEM;
    logic [DATA_W-1:0] instrMEM;
    logic [DATA_W-1:0] immMEM;
    logic [DATA_W-1:0] rdat1MEM;
    logic [DATA_W-1:0] rdat2MEM;
    logic [DATA_W-1:0] resultMEM;
    logic              zeroMEM;
    logic              jmpMEM;
    logic              jmprMEM;
    logic              j_alMEM;
    logic              b_eqMEM;
    logic              b_neMEM;
    logic              rf_writeMEM;
    logic              reg_dstMEM;
    logic              memtoregMEM;
    logic              dRENMEM;
    logic              dWENMEM;
    logic              haltMEM;

    logic              dhit;
    logic [DATA_W-1:0] dmemload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [DATA_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;

    logic              mem_stall;
    logic              pc_redirect;
    logic [DATA_W-1:0] npc_target;
    logic              flush;
    logic              wb_wen;
    logic [4:0]        wb_wsel;
    logic [DATA_W-1:0] wb_wdat;
    logic              halt_out;
    logic [CNT_W-1:0]  stall_cycles;

    // Upstream pipeline / cache / register-file side
    modport master (
        output pcMEM, instrMEM, immMEM, rdat1MEM, rdat2MEM, resultMEM,
        output zeroMEM, jmpMEM, jmprMEM, j_alMEM, b_eqMEM, b_neMEM,
        output rf_writeMEM, reg_dstMEM, memtoregMEM, dRENMEM, dWENMEM, haltMEM,
        output dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  mem_stall, pc_redirect, npc_target, flush,
        input  wb_wen, wb_wsel, wb_wdat, halt_out, stall_cycles
    );

    // Memory stage side
    modport slave (
        input  pcMEM, instrMEM, immMEM, rdat1MEM, rdat2MEM, resultMEM,
        input  zeroMEM, jmpMEM, jmprMEM, j_alMEM, b_eqMEM, b_neMEM,
        input  rf_writeMEM, reg_dstMEM, memtoregMEM, dRENMEM, dWENMEM, haltMEM,
        input  dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output mem_stall, pc_redirect, npc_target, flush,
        output wb_wen, wb_wsel, wb_wdat, halt_out, stall_cycles
    );

endinterface

// File: rtl/mem_stage_branch_resolve.sv
// Combinational branch/jump resolution: taken flag, redirect target and pc+4.
module mem_stage_branch_resolve
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rdat1,
    input  logic              zero,
    input  logic              jmp,
    input  logic              jmpr,
    input  logic              b_eq,
    input  logic              b_ne,
    output logic              taken,
    output logic [DATA_W-1:0] npc_target,
    output logic [DATA_W-1:0] pc4
);

    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] j_target;

    assign pc4       = pc + DATA_W'(4);
    assign br_target = pc4 + (imm << 2);
    assign j_target  = DATA_W'(jump_target(pc4[DATA_W-1 -: 4], instr[25:0]));

    // jr beats j/jal, which beats a conditional branch
    always_comb begin
        taken      = valid & (jmp | jmpr | (b_eq & zero) | (b_ne & ~zero));
        npc_target = br_target;
        if (jmp)  npc_target = j_target;
        if (jmpr) npc_target = rdat1;
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: D-cache handshake, control-transfer resolution, MEM/WB latch,
// sticky halt and memory-stall cycle counter.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter logic [4:0]  RA_REG = mem_stage_pkg::RA_REG,
    parameter int unsigned CNT_W  = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    mem_stage_if.slave      bus
);

    mem_state_t        state;
    logic              bubble;
    logic              halted;
    logic              memop;
    logic              stall;
    logic              taken;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] pc4;

    logic              wb_load;
    logic              wen_nxt;
    logic [4:0]        wsel_nxt;
    logic [DATA_W-1:0] wdat_nxt;

    logic              wen_q;
    logic [4:0]        wsel_q;
    logic [DATA_W-1:0] wdat_q;
    logic              halt_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign bubble = (bus.instrMEM == '0);
    assign halted = (state == HALT);
    assign memop  = (bus.dRENMEM | bus.dWENMEM) & ~bubble;
    assign stall  = memop & ~bus.dhit & ~halted;

    // Write wins when both request bits are set
    assign bus.dmemWEN   = bus.dWENMEM & ~bubble & ~halted;
    assign bus.dmemREN   = bus.dRENMEM & ~bus.dWENMEM & ~bubble & ~halted;
    assign bus.dmemaddr  = bus.resultMEM;
    assign bus.dmemstore = bus.rdat2MEM;
    assign bus.mem_stall = stall;

    mem_stage_branch_resolve #(.DATA_W(DATA_W)) u_branch_resolve (
        .valid      (~bubble & ~halted),
        .pc         (bus.pcMEM),
        .instr      (bus.instrMEM),
        .imm        (bus.immMEM),
        .rdat1      (bus.rdat1MEM),
        .zero       (bus.zeroMEM),
        .jmp        (bus.jmpMEM),
        .jmpr       (bus.jmprMEM),
        .b_eq       (bus.b_eqMEM),
        .b_ne       (bus.b_neMEM),
        .taken      (taken),
        .npc_target (target),
        .pc4        (pc4)
    );

    assign bus.pc_redirect = taken;
    assign bus.flush       = taken;
    assign bus.npc_target  = target;

    // Next MEM/WB contents; a stalled, bubbled or halted slot becomes all zero
    always_comb begin
        wb_load  = ~bubble & ~stall & ~halted;
        wsel_nxt = bus.j_alMEM ? RA_REG
                 : (bus.reg_dstMEM ? bus.instrMEM[15:11] : bus.instrMEM[20:16]);
        wdat_nxt = bus.memtoregMEM ? bus.dmemload
                 : (bus.j_alMEM ? pc4 : bus.resultMEM);
        wen_nxt  = bus.rf_writeMEM & (wsel_nxt != 5'd0);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= RUN;
            wen_q       <= 1'b0;
            wsel_q      <= 5'd0;
            wdat_q      <= '0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state)
                RUN, WAIT: begin
                    if (stall) begin
                        state <= WAIT;
                    end else if (~bubble & bus.haltMEM) begin
                        state  <= HALT;
                        halt_q <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase

            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            if (wb_load) begin
                wen_q  <= wen_nxt;
                wsel_q <= wsel_nxt;
                wdat_q <= wdat_nxt;
            end else begin
                wen_q  <= 1'b0;
                wsel_q <= 5'd0;
                wdat_q <= '0;
            end
        end
    end

    assign bus.wb_wen       = wen_q;
    assign bus.wb_wsel      = wsel_q;
    assign bus.wb_wdat      = wdat_q;
    assign bus.halt_out     = halt_q;
    assign bus.stall_cycles = stall_cnt_q;

endmodule
